// File: rtl/inv_expand192_if.sv
// Bus bundle for inv_expand192: load/advance controls in, round key stream out.
// key0/key0_valid exist only when INV_EXPAND192_KEY0_OUT_EN is defined.
interface inv_expand192_if;
  localparam int unsigned KEY_W = 192;
  localparam int unsigned RK_W  = 128;
  localparam int unsigned IDX_W = 4;

  logic             start;
  logic [KEY_W-1:0] key_in;
  logic             en;
  logic [RK_W-1:0]  round_key;
  logic [IDX_W-1:0] round_idx;
  logic             valid;
  logic             done;
`ifdef INV_EXPAND192_KEY0_OUT_EN
  logic [KEY_W-1:0] key0;
  logic             key0_valid;

  modport master (
    output start, key_in, en,
    input  round_key, round_idx, valid, done, key0, key0_valid
  );
  modport slave (
    input  start, key_in, en,
    output round_key, round_idx, valid, done, key0, key0_valid
  );
`else
  modport master (
    output start, key_in, en,
    input  round_key, round_idx, valid, done
  );
  modport slave (
    input  start, key_in, en,
    output round_key, round_idx, valid, done
  );
`endif
endinterface

// File: rtl/inv_expand192.sv
// AES-192 inverse key expansion: loaded with w46..w51, emits RK12 down to RK0, one per enabled cycle.
// Optional macro INV_EXPAND192_KEY0_OUT_EN also recovers the original cipher key on key0.
module inv_expand192 (
  input logic            clk,
  input logic            reset,
  inv_expand192_if.slave bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned KEY_W  = 192;
  localparam int unsigned RK_W   = 128;
  localparam int unsigned IDX_W  = 4;
  localparam logic [IDX_W-1:0] IDX_FIRST = 4'd12;
  localparam logic [7:0]       RCON_INIT = 8'h80;

  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Run phase tracks b mod 6 (P0: 4, P1: 0, P2: 2), which fixes where rcon lands in a step.
  typedef enum logic [2:0] {S_IDLE, S_P0, S_P1, S_P2, S_DONE} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[~x];
  endfunction

  function automatic logic [WORD_W-1:0] sub_rot(input logic [WORD_W-1:0] x, input logic [7:0] rc);
    return {sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0]), sbox(x[31:24])} ^ {rc, 24'h000000};
  endfunction

  // Inverse of GF(2^8) doubling; walks rcon 80,40,...,01.
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? (8'((x ^ 8'h1b) >> 1) | 8'h80) : 8'(x >> 1);
  endfunction

  state_t           state;
  logic [KEY_W-1:0] win;
  logic [7:0]       rcon;
  logic [IDX_W-1:0] idx;
  logic             valid_q;
  logic             done_q;
`ifdef INV_EXPAND192_KEY0_OUT_EN
  logic [KEY_W-1:0] key0_q;
  logic             key0_valid_q;
`endif

  // Window words w[b..b+5], oldest in the top slot.
  logic [WORD_W-1:0] w0, w1, w2, w3, w4, w5;
  assign w0 = win[191:160];
  assign w1 = win[159:128];
  assign w2 = win[127:96];
  assign w3 = win[95:64];
  assign w4 = win[63:32];
  assign w5 = win[31:0];

  // Older words w[b-1..b-4]; only one position per step can need the rcon path, so one SubWord is shared.
  logic [WORD_W-1:0] g_in, g_out, wm1, wm2, wm3, wm4;
  always_comb begin
    g_in  = (state == S_P2) ? w3 : w1;
    g_out = sub_rot(g_in, rcon);
    wm1   = w5 ^ w4;
    wm2   = w4 ^ ((state == S_P2) ? g_out : w3);
    wm3   = w3 ^ w2;
    wm4   = w2 ^ ((state == S_P0) ? g_out : w1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      win     <= '0;
      rcon    <= RCON_INIT;
      idx     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef INV_EXPAND192_KEY0_OUT_EN
      key0_q       <= '0;
      key0_valid_q <= 1'b0;
`endif
    end else if (bus.start) begin
      state   <= S_P0;
      win     <= bus.key_in;
      rcon    <= RCON_INIT;
      idx     <= IDX_FIRST;
      valid_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef INV_EXPAND192_KEY0_OUT_EN
      key0_q       <= '0;
      key0_valid_q <= 1'b0;
`endif
    end else if (bus.en) begin
      case (state)
        S_P0, S_P1, S_P2: begin
          if (idx != '0) begin
            win <= {wm4, wm3, wm2, wm1, w0, w1};
            idx <= idx - IDX_W'(1);
            if (state != S_P1) rcon <= inv_xtime(rcon);
            case (state)
              S_P0:    state <= S_P1;
              S_P1:    state <= S_P2;
              default: state <= S_P0;
            endcase
`ifdef INV_EXPAND192_KEY0_OUT_EN
            if (idx == IDX_W'(1)) key0_q <= {wm2, wm1, win[KEY_W-1:64]};
`endif
          end else begin
            state   <= S_DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
`ifdef INV_EXPAND192_KEY0_OUT_EN
            key0_valid_q <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.round_key = win[RK_W-1:0];
  assign bus.round_idx = idx;
  assign bus.valid     = valid_q;
  assign bus.done      = done_q;
`ifdef INV_EXPAND192_KEY0_OUT_EN
  assign bus.key0       = key0_q;
  assign bus.key0_valid = key0_valid_q;
`endif

endmodule

// File: tb/tb_inv_expand192.sv
// Bench for inv_expand192: forward-expansion reference model checked every cycle, plus FIPS-197 A.2 literals.
module tb_inv_expand192;
  localparam logic [191:0] A2_KEY  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] A2_RK12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] A2_RK0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [191:0] ALT_KEY = 192'h8e73b0f7da0e6452c810f32b0001020304050607a5a5a5a5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   cmp_en = 1'b0;

  logic [7:0]  sb [256];
  logic [31:0] sched [52];
  logic [31:0] m_sched [52];
  logic        m_run, m_valid, m_done, m_k0v;
  logic [3:0]  m_idx;
  logic [127:0] m_rk;
  logic [191:0] m_k0;

  inv_expand192_if bus ();
  inv_expand192 dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} >> (8 - n);
    return d[7:0];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
  endfunction

  // Forward AES-192 key schedule into sched[0..51].
  task automatic expand(input logic [191:0] key);
    logic [7:0]  rc;
    logic [31:0] t;
    rc = 8'h01;
    for (int i = 0; i < 6; i++) sched[i] = key[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = sched[i-1];
      if (i % 6 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      sched[i] = sched[i-6] ^ t;
    end
  endtask

  // Reference: round r exposes schedule words 4r..4r+3, counting r down from 12.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run <= 1'b0; m_valid <= 1'b0; m_done <= 1'b0; m_idx <= 4'd0;
      m_rk <= '0; m_k0 <= '0; m_k0v <= 1'b0;
    end else if (bus.start) begin
      m_sched <= sched;
      m_run <= 1'b1; m_valid <= 1'b1; m_done <= 1'b0; m_idx <= 4'd12;
      m_rk <= {sched[48], sched[49], sched[50], sched[51]};
      m_k0 <= '0; m_k0v <= 1'b0;
    end else if (bus.en && m_run) begin
      if (m_idx != 4'd0) begin
        m_idx <= m_idx - 4'd1;
        m_rk <= {m_sched[4*m_idx-4], m_sched[4*m_idx-3], m_sched[4*m_idx-2], m_sched[4*m_idx-1]};
      end else begin
        m_run <= 1'b0; m_valid <= 1'b0; m_done <= 1'b1;
        m_k0 <= {m_sched[0], m_sched[1], m_sched[2], m_sched[3], m_sched[4], m_sched[5]};
        m_k0v <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_valid", 192'(bus.valid), 192'(m_valid));
      chk("cyc_done", 192'(bus.done), 192'(m_done));
      chk("cyc_idx", 192'(bus.round_idx), 192'(m_idx));
      chk("cyc_rk", 192'(bus.round_key), 192'(m_rk));
`ifdef INV_EXPAND192_KEY0_OUT_EN
      chk("cyc_key0_valid", 192'(bus.key0_valid), 192'(m_k0v));
      if (m_k0v) chk("cyc_key0", bus.key0, m_k0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [191:0] key);
    expand(key);
    bus.key_in = {sched[46], sched[47], sched[48], sched[49], sched[50], sched[51]};
    bus.start  = 1'b1;
    bus.en     = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic wait_idx(input logic [3:0] target, input string name);
    int n;
    n = 0;
    while (bus.round_idx !== target && n < 40) begin
      tick();
      n++;
    end
    chk(name, 192'(bus.round_idx), 192'(target));
  endtask

  initial begin
    int n_en;
    bit got;
    logic [191:0] k;
    bus.start  = 1'b0;
    bus.en     = 1'b0;
    bus.key_in = '0;
    for (int x = 0; x < 256; x++) sb[x] = sbox_model(8'(x));
    #2 reset = 1'b0;
    #1 cmp_en = 1'b1;
    tick();
    tick();
    chk("reset_valid", 192'(bus.valid), 192'(0));
    chk("reset_done", 192'(bus.done), 192'(0));
    chk("reset_idx", 192'(bus.round_idx), 192'(0));
    chk("reset_rk", 192'(bus.round_key), 192'(0));
    reset = 1'b1;
    tick();
    tick();

    // Pin the reference against the published A.2 schedule.
    expand(A2_KEY);
    chk("model_rk12", 192'({sched[48], sched[49], sched[50], sched[51]}), 192'(A2_RK12));
    chk("model_sbox53", 192'(sb[8'h53]), 192'(8'hed));

    // Straight run, en held high.
    load(A2_KEY);
    chk("a2_rk12", 192'(bus.round_key), 192'(A2_RK12));
    chk("a2_idx12", 192'(bus.round_idx), 192'(12));
    repeat (12) tick();
    chk("a2_rk0", 192'(bus.round_key), 192'(A2_RK0));
    chk("a2_idx0", 192'(bus.round_idx), 192'(0));
    chk("a2_valid_last", 192'(bus.valid), 192'(1));
    chk("a2_done_early", 192'(bus.done), 192'(0));
    tick();
    chk("a2_done", 192'(bus.done), 192'(1));
    chk("a2_valid_off", 192'(bus.valid), 192'(0));
`ifdef INV_EXPAND192_KEY0_OUT_EN
    chk("a2_key0", bus.key0, A2_KEY);
`endif
    repeat (3) tick();
    chk("a2_rk0_hold", 192'(bus.round_key), 192'(A2_RK0));

    // Stalled run: en pattern 1,0,0,1.
    load(A2_KEY);
    n_en = 0;
    got  = 1'b0;
    for (int c = 0; c < 80 && !got; c++) begin
      bus.en = (c % 4 == 0) || (c % 4 == 3);
      tick();
      if (bus.en) n_en++;
      if (bus.done) got = 1'b1;
    end
    chk("stall_steps", 192'(n_en), 192'(13));
    chk("stall_rk0", 192'(bus.round_key), 192'(A2_RK0));
    bus.en = 1'b1;

    // Restart mid-run with a different key.
    load(A2_KEY);
    wait_idx(4'd7, "restart_reach7");
    k = ALT_KEY;
    load(k);
    chk("restart_idx", 192'(bus.round_idx), 192'(12));
    chk("restart_rk12", 192'(bus.round_key), 192'({sched[48], sched[49], sched[50], sched[51]}));
    repeat (12) tick();
    chk("restart_rk0", 192'(bus.round_key), 192'(k[191:64]));
    tick();
    chk("restart_done", 192'(bus.done), 192'(1));
`ifdef INV_EXPAND192_KEY0_OUT_EN
    chk("restart_key0", bus.key0, k);
`endif

    // Asynchronous reset between edges.
    load(A2_KEY);
    wait_idx(4'd5, "reset_reach5");
    #2 reset = 1'b0;
    #1;
    chk("areset_valid", 192'(bus.valid), 192'(0));
    chk("areset_done", 192'(bus.done), 192'(0));
    chk("areset_rk", 192'(bus.round_key), 192'(0));
    chk("areset_idx", 192'(bus.round_idx), 192'(0));
    tick();
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("post_reset_idle", 192'(bus.valid), 192'(0));

    // Random keys.
    for (int t = 0; t < 3; t++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      load(k);
      repeat (12) tick();
      chk("rand_rk0", 192'(bus.round_key), 192'(k[191:64]));
      tick();
      chk("rand_done", 192'(bus.done), 192'(1));
`ifdef INV_EXPAND192_KEY0_OUT_EN
      chk("rand_key0_valid", 192'(bus.key0_valid), 192'(1));
      chk("rand_key0", bus.key0, k);
`endif
    end

    tick();
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_expand192.md
Name: inv_expand192

Overview:
- AES-192 inverse key expansion for the decryption datapath.
- Loaded with the last six words of the AES-192 key schedule (w46..w51).
- Runs the schedule recurrence backwards and emits the 13 round keys in decryption order: RK12 first, RK0 last, one per enabled cycle.
- Sits beside the inverse cipher round logic, which consumes round_key each cycle.

Parameters:
- None. Key length is fixed at 192 bits; 13 round keys; 4 words per step.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- start  input  1  single-cycle load strobe
- key_in  input  192  decryption key {w46,w47,w48,w49,w50,w51}; w46 in [191:160]
- en  input  1  advance enable; 0 holds all state (stall)
- round_key  output  128  current round key {w4r..w4r+3}, lowest word in [127:96]
- round_idx  output  4  index r of round_key (12 down to 0)
- valid  output  1  round_key/round_idx meaningful
- done  output  1  high after RK0 has been presented and consumed

Behaviour:
- Reset (asynchronous, reset=0): state IDLE, window=0, rcon=8'h80, round_idx=0, valid=0, done=0, round_key=0.
- Window register win[191:0] holds six consecutive words w[b..b+5]; round_key = win[127:0] (words b+2..b+5).
- start (any state, en ignored): win<=key_in, b=46, rcon<=8'h80, round_idx<=12, state<=RUN phase P0, valid<=1, done<=0. RK12 is visible the cycle after start.
- RUN step, taken when en=1 and round_idx>0. Computes the 4 older words for i=b+5 down to b+2, chained:
  - w[i-6] = w[i] ^ w[i-1] when i mod 6 != 0.
  - w[i-6] = w[i] ^ (SubWord(RotWord(w[i-1])) ^ {rcon,24'b0}) when i mod 6 == 0.
  - Then win <= {w[b-4..b-1], win[191:128]}; round_idx <= round_idx-1.
- Phase FSM P0->P1->P2->P0, advanced only on a step:
  - P0 (b mod 6=4): rcon applied on the 4th word.
  - P1 (b mod 6=0): no rcon.
  - P2 (b mod 6=2): rcon applied on the 2nd word.
  - rcon <= inverse-xtime(rcon) after each step in which it was used: 80,40,20,10,08,04,02,01.
  - Last use (i=6) is in the final step.
- Words with negative index (w-1, w-2 in the final step) are don't-care.
- Final consumption: en=1 with round_idx==0 -> state DONE, valid<=0, done<=1. round_key holds RK0 until the next start.
- en=0: no state change; valid/round_key stable.
- Latency: RK(12-k) is presented k+1 cycles after start with en held high. 13 valid cycles total; done asserts on cycle 14.
- start while RUN: restart immediately; partial results discarded.
- Reset mid-run: all state returns to reset values asynchronously.
- start coincident with en: start wins.
- IDLE/DONE with en=1 and no start: no change.

Optional Feature:
- Macro INV_EXPAND192_KEY0_OUT_EN.
- Defined:
  - Adds output key0[191:0] and key0_valid.
  - The final RUN step registers key0 <= {w0,w1,w2,w3,w4,w5}, taken from the computed words plus win[191:64] at that step.
  - key0_valid rises with done.
  - Both clear on reset and on start.
- Undefined: no extra ports or registers.

Test Plan:
- FIPS-197 A.2 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b; load key_in={w46..w51} from A.2, en=1 -> RK12=e98ba06f448c773c8ecc720401002202 idx 12 on cycle 1. Each round_key matches A.2 schedule. RK0=8e73b0f7da0e6452c810f32b809079e5 idx 0 on cycle 13. done=1 on cycle 14.
- Same load; en toggled 1,0,0,1 pattern -> round_idx/round_key frozen while en=0; same 13-key sequence; done only after 13 enabled steps.
- Restart: start again after idx reaches 7 with a different A.2-derived key -> next cycle idx=12 with the new RK12; rcon sequence restarts at 80.
- Async reset (reset=0) mid-run at idx 5, between clock edges -> valid=0, done=0, round_key=0 immediately. After release, no activity without start.
- Cross-check: random 192-bit key expanded by forward model; feed w46..w51 -> all 13 reverse round keys match. With INV_EXPAND192_KEY0_OUT_EN, key0 equals the original key when key0_valid=1.
